// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and parameter limits.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } spi_state_t;

    localparam int SPI_TRF_BIT_DEF = 12;
    localparam int CLK_DIV_MIN     = 3;

endpackage

// File: rtl/spi_clk_div.sv
// Timed-state divider: counts 0..CLK_DIV-1 while enabled and flags the last cycle.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic last_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    // Wraps on last_tick so consecutive timed states each get a full CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (!en || last_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign last_tick = en && (div_cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI initiator for the 12-bit SPI slave: MSB first, cs active-low, sclk idles low.
module spi_master
    import spi_pkg::*;
#(
    parameter int SPI_TRF_BIT = SPI_TRF_BIT_DEF,
    parameter int CLK_DIV     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SPI_TRF_BIT-1:0] din,
    output logic [SPI_TRF_BIT-1:0] dout,
    output logic                   done,
    output logic                   busy,
    output logic                   sclk,
    output logic                   cs,
    output logic                   mosi,
    input  logic                   miso
);

    if (CLK_DIV < CLK_DIV_MIN) begin : g_bad_div
        $error("spi_master: CLK_DIV must be at least %0d", CLK_DIV_MIN);
    end
    if (SPI_TRF_BIT < 2 || SPI_TRF_BIT > 15) begin : g_bad_width
        $error("spi_master: SPI_TRF_BIT must be in 2..15");
    end

    localparam logic [3:0] LAST_BIT = 4'(SPI_TRF_BIT - 1);

    spi_state_t state, state_d;

    logic [SPI_TRF_BIT-1:0] tx_sh, tx_sh_d;
    logic [SPI_TRF_BIT-1:0] rx_sh, rx_sh_d;
    logic [SPI_TRF_BIT-1:0] dout_d;
    logic [3:0]             bit_cnt, bit_cnt_d;
    logic                   cs_d, sclk_d, mosi_d, done_d, busy_d;
    logic                   div_en;
    logic                   last_tick;

    assign div_en = (state != IDLE);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (div_en),
        .last_tick (last_tick)
    );

    always_comb begin
        state_d   = state;
        tx_sh_d   = tx_sh;
        rx_sh_d   = rx_sh;
        bit_cnt_d = bit_cnt;
        dout_d    = dout;
        cs_d      = cs;
        sclk_d    = sclk;
        mosi_d    = mosi;
        done_d    = 1'b0;
        busy_d    = busy;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d   = SETUP;
                    tx_sh_d   = din;
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            SETUP: begin
                if (last_tick) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                    mosi_d  = tx_sh[SPI_TRF_BIT-1];
                end
            end
            HIGH: begin
                // Slave has had the whole high phase to settle miso.
                if (last_tick) begin
                    state_d = LOW;
                    sclk_d  = 1'b0;
                    rx_sh_d = {rx_sh[SPI_TRF_BIT-2:0], miso};
                end
            end
            LOW: begin
                if (last_tick) begin
                    tx_sh_d   = tx_sh << 1;
                    bit_cnt_d = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_d = HOLD;
                    end else begin
                        // tx_sh shifts on this same edge, so the next bit is one below the MSB.
                        state_d = HIGH;
                        sclk_d  = 1'b1;
                        mosi_d  = tx_sh[SPI_TRF_BIT-2];
                    end
                end
            end
            HOLD: begin
                if (last_tick) begin
                    state_d = GAP;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    dout_d  = rx_sh;
                end
            end
            GAP: begin
                if (last_tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    mosi_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            dout    <= '0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            tx_sh   <= tx_sh_d;
            rx_sh   <= rx_sh_d;
            bit_cnt <= bit_cnt_d;
            dout    <= dout_d;
            cs      <= cs_d;
            sclk    <= sclk_d;
            mosi    <= mosi_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master against a behavioural SPI slave and transfer-level expectations.
module tb_spi_master;

    localparam int N = 12;
    localparam int D = 4;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] din   = '0;
    logic [N-1:0] dout;
    logic         done, busy, sclk, cs, mosi;
    logic         miso  = 1'b0;

    always #5 clk = ~clk;

    spi_master #(
        .SPI_TRF_BIT (N),
        .CLK_DIV     (D)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .dout  (dout),
        .done  (done),
        .busy  (busy),
        .sclk  (sclk),
        .cs    (cs),
        .mosi  (mosi),
        .miso  (miso)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave: drives miso after sclk rises, samples mosi after sclk falls.
    logic [N-1:0] s_tx_word = '0;
    logic [N-1:0] s_tx_sh   = '0;
    logic [N-1:0] s_rx      = '0;
    logic         s_sclk_q  = 1'b0;

    always @(posedge clk) begin
        s_sclk_q <= sclk;
        if (cs) begin
            s_tx_sh <= s_tx_word;
            miso    <= 1'b0;
        end else if (sclk && !s_sclk_q) begin
            miso    <= s_tx_sh[N-1];
            s_tx_sh <= s_tx_sh << 1;
        end else if (!sclk && s_sclk_q) begin
            s_rx <= {s_rx[N-2:0], mosi};
        end
    end

    // Pin-level monitor, sampled on the falling clk edge.
    int           cyc = 0;
    logic         cs_q = 1'b1;
    logic         sclk_q = 1'b0;
    int           t_csfall = 0, t_csrise = 0, cs_low_len = 0, cs_high_len = 0;
    int           rise_cnt = 0, fall_cnt = 0, t_lastrise = 0, first_rise_off = 0, bad_spacing = 0;
    int           cs_fall_total = 0;
    logic [N-1:0] mosi_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cs_q   <= cs;
        sclk_q <= sclk;
        if (cs_q && !cs) begin
            t_csfall      <= cyc;
            cs_high_len   <= cyc - t_csrise;
            cs_fall_total <= cs_fall_total + 1;
            rise_cnt      <= 0;
            fall_cnt      <= 0;
            bad_spacing   <= 0;
            mosi_word     <= '0;
        end
        if (!cs_q && cs) begin
            t_csrise   <= cyc;
            cs_low_len <= cyc - t_csfall;
        end
        if (!sclk_q && sclk) begin
            rise_cnt   <= rise_cnt + 1;
            t_lastrise <= cyc;
            if (rise_cnt == 0) first_rise_off <= cyc - t_csfall;
            else if (cyc - t_lastrise != 2 * D) bad_spacing <= bad_spacing + 1;
        end
        if (sclk_q && !sclk) begin
            fall_cnt  <= fall_cnt + 1;
            mosi_word <= {mosi_word[N-2:0], mosi};
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    // One transfer with full protocol checks; expected values come from the words and the timing rules.
    task automatic xfer(input logic [N-1:0] mw, input logic [N-1:0] sw, input bit toggle);
        int k;
        int t_req;
        int t_done;
        wait_idle();
        s_tx_word = sw;
        din       = mw;
        start     = 1'b1;
        t_req     = cyc;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            if (toggle) din = N'($urandom);
            k++;
        end
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
            return;
        end
        t_done = cyc;
        check("master_dout", {20'd0, dout}, {20'd0, sw});
        check("slave_rx", {20'd0, s_rx}, {20'd0, mw});
        check("start_to_done", t_done - t_req, 105);
        @(negedge clk);
        check("done_width", {31'd0, done}, 32'd0);
        check("cs_fall_lat", t_csfall - t_req, 1);
        check("cs_low_len", cs_low_len, D * (2 * N + 2));
        check("first_rise", first_rise_off, D);
        check("rise_cnt", rise_cnt, N);
        check("fall_cnt", fall_cnt, N);
        check("rise_spacing", bad_spacing, 0);
        check("mosi_word", {20'd0, mosi_word}, {20'd0, mw});
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("busy_fall", cyc - t_done, D);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int falls0;
        logic [N-1:0] sw1, sw2;

        repeat (3) @(negedge clk);
        check("reset_pins", {27'd0, cs, sclk, mosi, busy, done}, 32'b10000);
        check("reset_dout", {20'd0, dout}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        xfer(12'hA5C, 12'h3F1, 1'b0);
        xfer(12'h5A3, 12'h800, 1'b0);
        xfer(12'h3C6, 12'h001, 1'b0);
        xfer(12'hC3A, 12'hFFF, 1'b1);

        // Abort mid-transfer with a 3-cycle reset.
        wait_idle();
        s_tx_word = 12'h123;
        din       = 12'h456;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_pins", {27'd0, cs, sclk, mosi, busy, done}, 32'b10000);
        end
        check("abort_dout", {20'd0, dout}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            xfer(N'($urandom), N'($urandom), i[0]);
        end

        // Back-to-back with start held high.
        wait_idle();
        sw1 = N'($urandom);
        sw2 = N'($urandom);
        falls0    = cs_fall_total;
        s_tx_word = sw1;
        din       = 12'hFFF;
        start     = 1'b1;
        @(negedge clk);
        din = 12'h000;
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done1", {31'd0, done}, 32'd1);
        check("b2b_dout1", {20'd0, dout}, {20'd0, sw1});
        check("b2b_srx1", {20'd0, s_rx}, 32'hFFF);
        s_tx_word = sw2;
        @(negedge clk);
        check("b2b_rise1", rise_cnt, N);
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("b2b_done2", {31'd0, done}, 32'd1);
        check("b2b_dout2", {20'd0, dout}, {20'd0, sw2});
        check("b2b_srx2", {20'd0, s_rx}, 32'h000);
        check("b2b_cs_gap", cs_high_len, D + 1);
        @(negedge clk);
        check("b2b_rise2", rise_cnt, N);
        wait_idle();
        repeat (4) @(negedge clk);
        check("b2b_cs_falls", cs_fall_total - falls0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator that drives sclk, cs and mosi, and captures miso, for the existing 12-bit SPI slave.
- Matches the slave's timing: the slave drives miso after sclk rises and samples mosi on sclk falling edges. Transfers are MSB first, cs is active-low, sclk idles low.
- Runs on the same system clk as the slave. It sits between a host-side request interface (start/din/dout/done) and the SPI pins.

Parameters:
- SPI_TRF_BIT, 12, bits per transfer; legal range 2..15.
- CLK_DIV, 4, clk cycles per sclk half-period; minimum 3, because the slave edge-detects sclk and updates miso on clk.

Ports:
- clk  input  1  system clock; every flop is posedge clk.
- rst  input  1  synchronous reset, active-low.
- start  input  1  transfer request; sampled only in IDLE.
- din  input  SPI_TRF_BIT  transmit word; latched on an accepted start.
- dout  output  SPI_TRF_BIT  last received word; valid from done, held until the next done.
- done  output  1  one-cycle pulse at transfer end.
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- sclk  output  1  SPI clock.
- cs  output  1  chip select, active-low.
- mosi  output  1  serial data to the slave.
- miso  input  1  serial data from the slave.

Behaviour:
- Reset (rst=0 at posedge clk) values: cs=1, sclk=0, mosi=0, done=0, busy=0, dout=0, state=IDLE. All counters and shift registers are cleared.
- Reset mid-transfer aborts at once: cs rises on the reset clock and no done pulse is issued.
- All outputs are registered.
- Counters:
  - div_cnt counts 0..CLK_DIV-1 and sets the length of each timed state.
  - bit_cnt is 4 bits wide and counts 0..SPI_TRF_BIT-1.
- IDLE: outputs are at their reset values except dout. If start=1, latch din into tx_sh, clear rx_sh, go to SETUP; cs=0 and busy=1 from the next cycle. start is ignored outside IDLE.
- SETUP: lasts CLK_DIV cycles with cs=0 and sclk=0. This lets the slave enter its active state before the first rising edge. Then go to HIGH.
- HIGH: lasts CLK_DIV cycles.
  - On entry: sclk=1 and mosi=tx_sh[SPI_TRF_BIT-1].
  - On the last cycle of HIGH: shift rx_sh left, taking miso in at bit 0.
  - Then go to LOW.
- LOW: lasts CLK_DIV cycles.
  - On entry: sclk=0, and mosi stays stable through the falling edge.
  - On the last cycle of LOW: shift tx_sh left and increment bit_cnt.
  - If bit_cnt was SPI_TRF_BIT-1, go to HOLD; otherwise go to HIGH.
- HOLD: lasts CLK_DIV cycles with cs=0, sclk=0 and mosi held. On the last cycle, cs rises on the next clk edge.
  - On that edge dout<=rx_sh and done=1 for exactly one cycle.
  - Go to GAP.
- GAP: lasts CLK_DIV cycles with cs=1 and busy=1, giving a minimum deselect time. Then go to IDLE.
- Timing for the default parameters:
  - cs is low for CLK_DIV*(2*SPI_TRF_BIT+2) = 104 cycles.
  - start-to-done is 105 cycles.
  - start-to-IDLE is 109 cycles.
- Back-to-back transfers: start held high in the IDLE cycle right after GAP is accepted immediately. The next cs fall is CLK_DIV+1 cycles after the previous cs rise.
- Exactly SPI_TRF_BIT rising and SPI_TRF_BIT falling sclk edges occur per transfer; no extra edges.
- din changes while busy do not affect the word in flight.

Decomposition:
- Shared package spi_pkg holds:
  - the state encoding (IDLE, SETUP, HIGH, LOW, HOLD, GAP);
  - the SPI_TRF_BIT default;
  - the CLK_DIV minimum of 3.
- One natural sub-module: spi_clk_div. It takes clk, rst, en and CLK_DIV and produces a one-cycle last_tick that marks the end of every timed state.
- The FSM and shift registers stay in spi_master.

Test Plan:
- Reset: rst=0 for 3 cycles mid-transfer -> cs=1, sclk=0, mosi=0, busy=0, no done pulse; a new start afterwards completes normally.
- Loopback with the slave (slave reset driven as the inverse of rst): master din=0xA5C, slave din=0x3F1 -> master dout=0x3F1 at done, and slave dout=0xA5C. Check slave dout during HOLD, while cs is still low, because the slave clears its output when cs rises.
- Timing at CLK_DIV=4:
  - cs falls 1 cycle after start;
  - first sclk rise is 4 cycles after cs falls;
  - there are 12 rising edges spaced 8 cycles apart;
  - cs rises 104 cycles after it falls;
  - done is high for exactly 1 cycle and busy falls 4 cycles later.
- Back-to-back: start held high for 300 cycles with din=0xFFF then 0x000 -> two transfers, each with 12 sclk pulses and cs high for exactly 5 cycles between them; start is ignored while busy.
- Edge patterns: slave din=0x800 and 0x001 -> master dout equals each value exactly, confirming MSB-first order with no bit-shift off-by-one.
- Stability: toggle din every cycle while busy -> mosi carries only the word latched at start.
